// File: rtl/calc_pkg.sv
// Shared constants for the calculator sequencing controller: state encodings,
// opcode values and operand width.
package calc_pkg;

  localparam int CALC_W = 8;

  // State encodings (exposed on state_code for the display).
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT_B = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [2:0] OP_XOR  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_LAST = OP_SUB;

  function automatic logic op_supported(input logic [2:0] op);
    return (op <= OP_LAST);
  endfunction

endpackage

// File: rtl/calc_controller_edge_rise.sv
// Registered rising-edge detector; the sampled copy resets low so a level
// held high through reset release reads as one rising edge.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/calc_controller.sv
// Sequencing controller for the 8-bit calculator: captures A, B and opcode on
// Enter events, holds ALU inputs for a settle interval, then latches the result.
module calc_controller
  import calc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enter,
  input  logic              clear,
  input  logic [CALC_W-1:0] sw,
  input  logic [2:0]        op_sel,
  output logic [2:0]        alu_opcode,
  output logic [CALC_W-1:0] alu_in1,
  output logic [CALC_W-1:0] alu_in2,
  input  logic [CALC_W-1:0] alu_result,
  output logic [CALC_W-1:0] result,
  output logic              result_valid,
  output logic              busy,
  output logic              op_err,
  output logic [2:0]        state_code
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  // Handshake: there is no valid/ready pair here; an Enter rising edge is the
  // only request, accepted in IDLE/WAIT_B/DONE and dropped while in EXEC.
  logic              enter_rise;
  logic [1:0]        state;
  logic [CALC_W-1:0] a_reg;
  logic [CALC_W-1:0] b_reg;
  logic [2:0]        op_reg;
  logic [CALC_W-1:0] result_reg;
  logic              op_err_reg;
  logic [3:0]        settle_cnt;

  edge_rise u_enter_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (enter),
    .rise  (enter_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      result_reg <= '0;
      op_err_reg <= 1'b0;
      settle_cnt <= '0;
    end else if (clear) begin
      state      <= ST_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      result_reg <= '0;
      op_err_reg <= 1'b0;
      settle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enter_rise) begin
            a_reg <= sw;
            state <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (enter_rise) begin
            b_reg  <= sw;
            op_reg <= op_sel;
            if (op_supported(op_sel)) begin
              op_err_reg <= 1'b0;
              settle_cnt <= '0;
              state      <= ST_EXEC;
            end else begin
              // Unsupported opcode skips the settle interval entirely.
              result_reg <= '0;
              op_err_reg <= 1'b1;
              state      <= ST_DONE;
            end
          end
        end
        ST_EXEC: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_cnt == SETTLE_LAST) begin
            result_reg <= alu_result;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Chaining: the held result becomes operand A.
          if (enter_rise) begin
            a_reg <= result_reg;
            state <= ST_WAIT_B;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign alu_opcode   = op_reg;
  assign alu_in1      = a_reg;
  assign alu_in2      = b_reg;
  assign result       = result_reg;
  assign op_err       = op_err_reg;
  assign result_valid = (state == ST_DONE);
  assign busy         = (state == ST_EXEC);
  assign state_code   = {1'b0, state};

endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller with a behavioural ALU attached; all
// expected values are hand-computed constants.
module tb_calc_controller;

  logic       clk;
  logic       rst_n;
  logic       enter;
  logic       clear;
  logic [7:0] sw;
  logic [2:0] op_sel;
  logic [2:0] alu_opcode;
  logic [7:0] alu_in1;
  logic [7:0] alu_in2;
  logic [7:0] alu_result;
  logic [7:0] result;
  logic       result_valid;
  logic       busy;
  logic       op_err;
  logic [2:0] state_code;

  int n_checks = 0;
  int n_pass   = 0;

  calc_controller #(.SETTLE_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enter        (enter),
    .clear        (clear),
    .sw           (sw),
    .op_sel       (op_sel),
    .alu_opcode   (alu_opcode),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
    .alu_result   (alu_result),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .op_err       (op_err),
    .state_code   (state_code)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU standing in for the real datapath
  always_comb begin
    alu_result = 8'h00;
    case (alu_opcode)
      3'd0: alu_result = alu_in1 ^ alu_in2;
      3'd1: alu_result = alu_in1 & alu_in2;
      3'd2: alu_result = alu_in1 | alu_in2;
      3'd3: alu_result = alu_in1 + alu_in2;
      3'd4: alu_result = alu_in1 - alu_in2;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Driver tasks
  task automatic press(input logic [7:0] v, input logic [2:0] op);
    @(negedge clk);
    sw     = v;
    op_sel = op;
    enter  = 1'b1;
    @(negedge clk);
    enter  = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Called at the negedge right after a B capture; counts busy cycles.
  task automatic run_exec(input string tag, input logic [7:0] exp_result);
    int nb = 0;
    int guard = 0;
    while (busy && guard < 20) begin
      nb++;
      guard++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, nb, 2);
    check({tag, "_state"}, state_code, 3);
    check({tag, "_result"}, result, exp_result);
    check({tag, "_valid"}, result_valid, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; enter = 1'b0; clear = 1'b0; sw = 8'h00; op_sel = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_state", state_code, 0);
    check("rst_result", result, 8'h00);
    check("rst_valid", result_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_op_err", op_err, 1'b0);
    check("rst_in1", alu_in1, 8'h00);
    rst_n = 1'b1;

    // 0x0F + 0x33 = 0x42
    press(8'h0F, 3'd0);
    check("t1_state_a", state_code, 1);
    check("t1_in1", alu_in1, 8'h0F);
    press(8'h33, 3'd3);
    check("t1_state_b", state_code, 2);
    check("t1_busy", busy, 1'b1);
    check("t1_in2", alu_in2, 8'h33);
    check("t1_opcode", alu_opcode, 3'd3);
    run_exec("t1", 8'h42);

    // Chain: A comes from result, not sw; 0x42 ^ 0x42 = 0
    press(8'h99, 3'd0);
    check("t2_state_a", state_code, 1);
    check("t2_in1_chain", alu_in1, 8'h42);
    press(8'h42, 3'd0);
    check("t2_in1_exec", alu_in1, 8'h42);
    run_exec("t2", 8'h00);

    // Unsupported opcode goes straight to DONE
    do_clear();
    press(8'hF0, 3'd0);
    press(8'h3C, 3'd6);
    check("t3_state", state_code, 3);
    check("t3_result", result, 8'h00);
    check("t3_op_err", op_err, 1'b1);
    check("t3_busy", busy, 1'b0);
    check("t3_opcode", alu_opcode, 3'd6);
    press(8'h00, 3'd0);
    check("t3_chain_state", state_code, 1);
    check("t3_err_held", op_err, 1'b1);
    press(8'h05, 3'd2);
    check("t3_err_cleared", op_err, 1'b0);
    run_exec("t3", 8'h05);

    // Enter held for 10 cycles: one capture only
    do_clear();
    @(negedge clk);
    sw = 8'h11; enter = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) sw = 8'h22;
    end
    enter = 1'b0;
    check("t4_hold_state", state_code, 1);
    check("t4_hold_in1", alu_in1, 8'h11);
    // Enter pulsed during EXEC is ignored
    @(negedge clk);
    sw = 8'h01; op_sel = 3'd3; enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    sw = 8'hAA;
    @(negedge clk);
    enter = 1'b1;
    check("t4_exec_state", state_code, 2);
    @(negedge clk);
    check("t4_after_state", state_code, 3);
    check("t4_in2_kept", alu_in2, 8'h01);
    check("t4_result", result, 8'h12);
    enter = 1'b0;

    // clear wins over simultaneous enter rise in WAIT_B
    press(8'h00, 3'd0);
    check("t5_pre_state", state_code, 1);
    check("t5_pre_in1", alu_in1, 8'h12);
    @(negedge clk);
    sw = 8'h77; op_sel = 3'd1; enter = 1'b1; clear = 1'b1;
    @(negedge clk);
    check("t5_state", state_code, 0);
    check("t5_in1", alu_in1, 8'h00);
    check("t5_in2", alu_in2, 8'h00);
    check("t5_opcode", alu_opcode, 3'd0);
    check("t5_result", result, 8'h00);
    check("t5_op_err", op_err, 1'b0);
    clear = 1'b0; enter = 1'b0;

    // Asynchronous reset mid-EXEC
    press(8'h0F, 3'd0);
    press(8'h33, 3'd3);
    check("t6_pre_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_state", state_code, 0);
    check("t6_rst_in1", alu_in1, 8'h00);
    check("t6_rst_in2", alu_in2, 8'h00);
    sw = 8'hFF; enter = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    // Enter held through release counts as a rising edge on the first clock
    @(negedge clk);
    check("t6_rel_state", state_code, 1);
    check("t6_rel_in1", alu_in1, 8'hFF);
    enter = 1'b0;
    press(8'h01, 3'd3);
    run_exec("t6", 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
